// File: rtl/apb_cmd_master.sv
// Single-outstanding command-to-APB3 bridge: one command in, one APB transfer out, one response back.
// Optional wait-state timeout ends a stalled ACCESS phase with an error response.
module apb_cmd_master #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      CLK,
    input  logic                      RSTN,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [APB_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]               cmd_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [31:0]               rsp_rdata,
    output logic                      rsp_err,
    output logic                      rsp_timeout,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

    localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] TO_LAST = TO_EN ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

    state_e                    state_q, state_d;
    logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [31:0]               pwdata_q, pwdata_d;
    logic                      pwrite_q, pwrite_d;
    logic                      psel_q, psel_d;
    logic                      penable_q, penable_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic [31:0]               rsp_rdata_q, rsp_rdata_d;
    logic                      rsp_err_q, rsp_err_d;
    logic                      rsp_timeout_q, rsp_timeout_d;
    logic [15:0]               wait_cnt_q, wait_cnt_d;

    // NOTE: every signal written here gets its hold value first, so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pwrite_d      = pwrite_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        wait_cnt_d    = wait_cnt_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    paddr_d    = cmd_addr;
                    pwdata_d   = cmd_wdata;
                    pwrite_d   = cmd_write;
                    psel_d     = 1'b1;
                    wait_cnt_d = 16'd0;
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // PREADY is tested first so a completion on the timeout cycle still succeeds.
                if (PREADY) begin
                    rsp_rdata_d   = pwrite_q ? 32'd0 : PRDATA;
                    rsp_err_d     = PSLVERR;
                    rsp_timeout_d = 1'b0;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end else if (TO_EN && (wait_cnt_q == TO_LAST)) begin
                    rsp_rdata_d   = 32'd0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q       <= IDLE;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pwrite_q      <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            wait_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pwrite_q      <= pwrite_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    assign cmd_ready   = (state_q == IDLE);
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign PWRITE      = pwrite_q;
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Scoreboard bench for apb_cmd_master: directed commands push expected APB and response records,
// independent monitors pop and compare them as the DUT presents transfers and responses.
module tb_apb_cmd_master;

    typedef struct {
        logic        wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        int          len;
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [11:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [11:0] PADDR;
    logic [31:0] PWDATA, PRDATA;
    logic        PWRITE, PSEL, PENABLE, PREADY, PSLVERR;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_apb_q[$];
    exp_t exp_rsp_q[$];

    int          cfg_waits = 0;
    bit          cfg_never = 1'b0;
    logic        cfg_err   = 1'b0;
    int          acc_cnt   = 0;
    int          psel_len  = 0;

    apb_cmd_master #(.APB_ADDR_WIDTH(12), .TIMEOUT_CYCLES(4)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // APB responder: PREADY after cfg_waits wait states, or never.
    always @(negedge CLK) begin
        if (RSTN && PSEL && PENABLE) begin
            PREADY  = !cfg_never && (acc_cnt == cfg_waits);
            PSLVERR = PREADY && cfg_err;
            acc_cnt++;
        end else begin
            PREADY  = 1'b0;
            PSLVERR = 1'b0;
            acc_cnt = 0;
        end
    end

    // APB monitor: address phase contents, PENABLE sequencing and PSEL length per transfer.
    always @(negedge CLK) begin
        if (!RSTN) begin
            psel_len = 0;
        end else if (PSEL) begin
            if (exp_apb_q.size() == 0) begin
                check("apb_unexpected_psel", 32'(PSEL), 32'd0);
            end else begin
                check("paddr", 32'(PADDR), 32'(exp_apb_q[0].addr));
                check("pwrite", 32'(PWRITE), 32'(exp_apb_q[0].wr));
                check("pwdata", PWDATA, exp_apb_q[0].wdata);
                check("penable", 32'(PENABLE), 32'(psel_len != 0));
            end
            psel_len++;
        end else if (psel_len != 0) begin
            if (exp_apb_q.size() != 0) begin
                check("psel_len", 32'(psel_len), 32'(exp_apb_q[0].len));
                void'(exp_apb_q.pop_front());
            end
            psel_len = 0;
        end
    end

    // Response monitor: compare at every handshake.
    always @(negedge CLK) begin
        if (RSTN && rsp_valid && rsp_ready) begin
            if (exp_rsp_q.size() == 0) begin
                check("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                check("rsp_rdata", rsp_rdata, exp_rsp_q[0].rdata);
                check("rsp_err", 32'(rsp_err), 32'(exp_rsp_q[0].err));
                check("rsp_timeout", 32'(rsp_timeout), 32'(exp_rsp_q[0].to));
                void'(exp_rsp_q.pop_front());
            end
        end
    end

    task automatic issue(input exp_t e, input int waits, input bit never,
                         input logic [31:0] prd, input logic perr);
        bit ok = 1'b0;
        @(posedge CLK); #1;
        cfg_waits = waits;
        cfg_never = never;
        cfg_err   = perr;
        PRDATA    = prd;
        exp_apb_q.push_back(e);
        exp_rsp_q.push_back(e);
        cmd_valid = 1'b1;
        cmd_write = e.wr;
        cmd_addr  = e.addr;
        cmd_wdata = e.wdata;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("cmd_accept", 32'(ok), 32'd1);
        @(posedge CLK); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200; i++) begin
            if (exp_rsp_q.size() == 0 && exp_apb_q.size() == 0) break;
            @(negedge CLK);
        end
        check("txn_outstanding", 32'(exp_rsp_q.size() + exp_apb_q.size()), 32'd0);
    endtask

    function automatic exp_t mk(input logic wr, input logic [11:0] addr, input logic [31:0] wd,
                                input int len, input logic [31:0] rd, input logic err,
                                input logic to);
        exp_t e;
        e.wr = wr; e.addr = addr; e.wdata = wd; e.len = len;
        e.rdata = rd; e.err = err; e.to = to;
        return e;
    endfunction

    initial begin
        bit seen;
        RSTN = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b1; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RSTN = 1'b1;

        @(negedge CLK);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_psel", 32'(PSEL), 32'd0);
        check("rst_penable", 32'(PENABLE), 32'd0);
        check("rst_paddr", 32'(PADDR), 32'd0);
        check("rst_pwdata", PWDATA, 32'd0);
        check("rst_pwrite", 32'(PWRITE), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);

        // Zero-wait write with cycle-exact latency checks.
        issue(mk(1'b1, 12'h00C, 32'h0000_0083, 2, 32'd0, 1'b0, 1'b0), 0, 1'b0, 32'hA5A5_A5A5, 1'b0);
        @(negedge CLK);
        check("lat_setup_psel", 32'(PSEL), 32'd1);
        check("lat_setup_penable", 32'(PENABLE), 32'd0);
        check("lat_setup_pwrite", 32'(PWRITE), 32'd1);
        @(negedge CLK);
        check("lat_access_penable", 32'(PENABLE), 32'd1);
        check("lat_access_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge CLK);
        check("lat_resp_valid", 32'(rsp_valid), 32'd1);
        check("lat_resp_psel", 32'(PSEL), 32'd0);
        @(negedge CLK);
        check("lat_next_cmd_ready", 32'(cmd_ready), 32'd1);
        check("lat_next_rsp_valid", 32'(rsp_valid), 32'd0);
        wait_done();

        // Read with three wait states; PREADY lands on the timeout cycle and must win.
        issue(mk(1'b0, 12'h014, 32'd0, 5, 32'h0000_0060, 1'b0, 1'b0), 3, 1'b0, 32'h0000_0060, 1'b0);
        wait_done();
        // Read with slave error.
        issue(mk(1'b0, 12'h020, 32'd0, 2, 32'hDEAD_BEEF, 1'b1, 1'b0), 0, 1'b0, 32'hDEAD_BEEF, 1'b1);
        wait_done();
        // Read that never gets PREADY: four ACCESS cycles then timeout.
        issue(mk(1'b0, 12'h030, 32'd0, 5, 32'd0, 1'b1, 1'b1), 0, 1'b1, 32'h5555_AAAA, 1'b0);
        wait_done();
        // Write completing on the fourth ACCESS cycle.
        issue(mk(1'b1, 12'h040, 32'h1234_5678, 5, 32'd0, 1'b0, 1'b0), 3, 1'b0, 32'h9999_9999, 1'b0);
        wait_done();
        // Write with error after one wait state, top address.
        issue(mk(1'b1, 12'hFFC, 32'hFFFF_FFFF, 3, 32'd0, 1'b1, 1'b0), 1, 1'b0, 32'h7777_7777, 1'b1);
        wait_done();

        // Response back-pressure with a competing command held valid.
        @(posedge CLK); #1 rsp_ready = 1'b0;
        issue(mk(1'b0, 12'h100, 32'd0, 4, 32'hCAFE_F00D, 1'b0, 1'b0), 2, 1'b0, 32'hCAFE_F00D, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("hold_rsp_seen", 32'(seen), 32'd1);
        @(posedge CLK); #1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h200; cmd_wdata = 32'h0BAD_0BAD;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            check("hold_rsp_rdata", rsp_rdata, 32'hCAFE_F00D);
            check("hold_rsp_err", 32'(rsp_err), 32'd0);
            check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
            check("hold_psel", 32'(PSEL), 32'd0);
        end
        @(posedge CLK); #1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_done();

        // Reset pulse during ACCESS aborts the transfer.
        issue(mk(1'b0, 12'h030, 32'd0, 5, 32'd0, 1'b1, 1'b1), 0, 1'b1, 32'h1111_1111, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (PSEL && PENABLE) begin
                seen = 1'b1;
                break;
            end
        end
        check("abort_access_seen", 32'(seen), 32'd1);
        @(posedge CLK); #1 RSTN = 1'b0;
        #1;
        check("abort_psel", 32'(PSEL), 32'd0);
        check("abort_penable", 32'(PENABLE), 32'd0);
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        exp_apb_q.delete();
        exp_rsp_q.delete();
        repeat (2) @(posedge CLK);
        #1 RSTN = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            check("post_abort_rsp_valid", 32'(rsp_valid), 32'd0);
            check("post_abort_psel", 32'(PSEL), 32'd0);
        end
        check("post_abort_paddr", 32'(PADDR), 32'd0);

        issue(mk(1'b0, 12'h008, 32'd0, 3, 32'h1122_3344, 1'b0, 1'b0), 1, 1'b0, 32'h1122_3344, 1'b0);
        wait_done();

        repeat (3) @(posedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
